// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state encoding and the
// wait-counter width.
package dmem_arbiter_pkg;

  localparam int ARB_WAITW = 8;

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_DBG = 2'd1,
    S_ACK = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_waitcnt.sv
// Saturating counter that tracks how long a debug request has waited
// behind the pipeline. Clear has priority over increment.
module arb_waitcnt
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [ARB_WAITW-1:0] cnt,
  output logic                 sat
);

  localparam logic [ARB_WAITW-1:0] MAX_CNT = ARB_WAITW'(MAX_WAIT);

  assign sat = (cnt == MAX_CNT);

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/simplemux.sv
// Generic two-input word multiplexer; sel=1 picks b.
module simplemux #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the ME stage and the debug host.
// Debug gets one-cycle slots via a four-phase req/ack handshake.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int FULLW    = 32,
  parameter int ADDRW    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cpu_en,
  input  logic             cpu_we,
  input  logic [ADDRW-1:0] cpu_addr,
  input  logic [FULLW-1:0] cpu_wd,
  output logic [FULLW-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [ADDRW-1:0] dbg_addr,
  input  logic [FULLW-1:0] dbg_wd,
  output logic             dbg_ack,
  output logic [FULLW-1:0] dbg_rdata,
  output logic [ADDRW-1:0] ram_addr,
  output logic             ram_we,
  output logic [FULLW-1:0] ram_wd,
  input  logic [FULLW-1:0] ram_rdata
);

  localparam int MUXW = ADDRW + FULLW + 1;

  arb_state_t           state;
  logic [ARB_WAITW-1:0] wait_cnt;
  logic                 wait_sat;
  logic                 dbg_sel;
  logic                 grant;
  logic                 cnt_clr;
  logic [MUXW-1:0]      mux_out;

  assign dbg_sel = (state == S_DBG);

  // An idle ME stage lets debug in at once; a busy one only after the
  // counter saturates, so debug can never starve.
  assign grant   = (state == S_CPU) && dbg_req && (!cpu_en || wait_sat);
  assign cnt_clr = (state != S_CPU) || !dbg_req || grant;

  arb_waitcnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_waitcnt (
    .clk    (clk),
    .nreset (nreset),
    .clr    (cnt_clr),
    .inc    (!cnt_clr),
    .cnt    (wait_cnt),
    .sat    (wait_sat)
  );

  // Write enable comes through the mux too, so a CPU store cannot reach the
  // RAM during a debug slot; the stall makes the pipeline replay it later.
  simplemux #(
    .W (MUXW)
  ) u_ram_mux (
    .a   ({cpu_addr, cpu_wd, cpu_en & cpu_we}),
    .b   ({dbg_addr, dbg_wd, dbg_we}),
    .sel (dbg_sel),
    .y   (mux_out)
  );

  assign {ram_addr, ram_wd, ram_we} = mux_out;
  assign cpu_rdata = ram_rdata;
  assign cpu_stall = dbg_sel & cpu_en;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_CPU;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        S_CPU: begin
          if (grant) state <= S_DBG;
        end
        S_DBG: begin
          if (!dbg_we) dbg_rdata <= ram_rdata;
          dbg_ack <= 1'b1;
          state   <= S_ACK;
        end
        S_ACK: begin
          if (!dbg_req) begin
            dbg_ack <= 1'b0;
            state   <= S_CPU;
          end
        end
        default: state <= S_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural combinational-read RAM.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cpu_en = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wd = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wd = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [31:0] ram_addr, ram_wd, ram_rdata;
  logic        ram_we;

  logic [31:0] mem [0:255] = '{default: '0};

  int n_checks = 0;
  int n_errors = 0;
  int stalled;

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[7:0]];
  always @(posedge clk) if (ram_we) mem[ram_addr[7:0]] <= ram_wd;

  dmem_arbiter u_dut (
    .clk       (clk),
    .nreset    (nreset),
    .cpu_en    (cpu_en),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wd    (dbg_wd),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wd    (ram_wd),
    .ram_rdata (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset and idle
    #12;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ack", dbg_ack, 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    nreset = 1'b1;
    tick();
    tick();
    chk("idle_stall", cpu_stall, 0);
    chk("idle_ack", dbg_ack, 0);
    chk("idle_ram_we", ram_we, 0);

    // 2. CPU store then load (also preloads 0x20 for the debug read)
    cpu_en = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wd = 32'hDEADBEEF;
    #1;
    chk("st_ram_we", ram_we, 1);
    chk("st_stall", cpu_stall, 0);
    tick();
    cpu_addr = 32'h20; cpu_wd = 32'h12345678;
    tick();
    cpu_we = 0; cpu_addr = 32'h10;
    #1;
    chk("ld_ram_we", ram_we, 0);
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("ld_stall", cpu_stall, 0);
    tick();

    // 3. Idle-CPU debug read of 0x20
    cpu_en = 0; cpu_addr = 32'h0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    #1;
    chk("dr_n_addr", ram_addr, 32'h0);
    tick();
    chk("dr_n1_addr", ram_addr, 32'h20);
    chk("dr_n1_we", ram_we, 0);
    chk("dr_n1_stall", cpu_stall, 0);
    chk("dr_n1_ack", dbg_ack, 0);
    tick();
    chk("dr_n2_ack", dbg_ack, 1);
    chk("dr_n2_rdata", dbg_rdata, 32'h12345678);
    chk("dr_n2_addr", ram_addr, 32'h0);
    tick();
    chk("dr_n3_ack", dbg_ack, 1);
    tick();
    dbg_req = 0;
    #1;
    chk("dr_n4_ack", dbg_ack, 1);
    tick();
    chk("dr_n5_ack", dbg_ack, 0);

    // Abandoned request clears the wait counter
    cpu_en = 1; cpu_we = 0; cpu_addr = 32'h50;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h70; dbg_wd = 32'h99;
    tick(); tick(); tick();
    chk("ab_cnt3", 32'(u_dut.wait_cnt), 3);
    dbg_req = 0;
    tick();
    chk("ab_cnt0", 32'(u_dut.wait_cnt), 0);
    chk("ab_no_write", mem[8'h70], 0);
    chk("ab_ack", dbg_ack, 0);

    // 4. Starvation: debug write forced through after 16 cycles
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h30; dbg_wd = 32'hA5A5A5A5;
    stalled = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (cpu_stall || ram_we) stalled++;
    end
    chk("sv_no_early", stalled, 0);
    chk("sv_cnt_sat", 32'(u_dut.wait_cnt), 15);
    tick();
    chk("sv_stall", cpu_stall, 1);
    chk("sv_addr", ram_addr, 32'h30);
    chk("sv_we", ram_we, 1);
    tick();
    cpu_addr = 32'h30; dbg_req = 0;
    #1;
    chk("sv_ack", dbg_ack, 1);
    chk("sv_stall_off", cpu_stall, 0);
    chk("sv_cpu_rd", cpu_rdata, 32'hA5A5A5A5);
    tick();
    chk("sv_ack_off", dbg_ack, 0);

    // 5. Collision: stalled CPU store to 0x40 lands after the debug write
    cpu_en = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wd = 32'h11111111;
    tick();
    cpu_en = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wd = 32'h22222222;
    #1;
    chk("co_stall", cpu_stall, 1);
    chk("co_ram_wd", ram_wd, 32'h11111111);
    chk("co_ram_we", ram_we, 1);
    tick();
    dbg_req = 0;
    #1;
    chk("co_dbg_first", mem[8'h40], 32'h11111111);
    chk("co_stall_off", cpu_stall, 0);
    chk("co_cpu_wd", ram_wd, 32'h22222222);
    tick();
    cpu_en = 0; cpu_we = 0;
    #1;
    chk("co_final", mem[8'h40], 32'h22222222);
    tick();

    // 6. Reset during the S_DBG cycle
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h60; dbg_wd = 32'h77777777;
    tick();
    chk("rd_in_dbg", ram_we, 1);
    #2;
    nreset = 0;
    #1;
    chk("rd_we_sup", ram_we, 0);
    chk("rd_ack", dbg_ack, 0);
    chk("rd_state", 32'(u_dut.state), 32'(S_CPU));
    tick();
    chk("rd_no_write", mem[8'h60], 0);
    dbg_req = 0;
    #2;
    nreset = 1;
    tick();
    chk("rd_state_rel", 32'(u_dut.state), 32'(S_CPU));
    chk("rd_cnt", 32'(u_dut.wait_cnt), 0);
    chk("rd_ack_rel", dbg_ack, 0);
    chk("rd_no_write2", mem[8'h60], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
